prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000, instruction-memory address of word 0.
REQ-002 Parameter MAX_WORDS, default 1024, largest accepted word count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begins a load; sampled each cycle.
REQ-006 in_valid  input  1  byte-stream source has in_data valid.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_wr_en  output  1  one-cycle write strobe to instruction memory.
REQ-010 imem_wr_addr  output  16  instruction-memory write address.
REQ-011 imem_wr_data  output  16  instruction word to write.
REQ-012 cpu_reset  output  1  holds the CPU core in reset while high.
REQ-013 done  output  1  load completed and checksum matched.
REQ-014 err  output  1  load aborted: oversize count or checksum mismatch.
REQ-015 count  output  16  number of words written in the current or last load.

Function
REQ-016 A byte transfers only in a cycle where in_valid and in_ready are both 1.
REQ-017 Stream format SHALL be: count high byte, count low byte, then N words (each high byte first), then one checksum byte.
REQ-018 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERROR.
REQ-019 in_ready SHALL be 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHK.
REQ-020 IDLE/DONE/ERROR + start -> LEN_HI; start in any other state is ignored.
REQ-021 On entry to LEN_HI: count=0, running checksum=0, done=0, err=0, cpu_reset=1.
REQ-022 LEN_HI transfer -> LEN_LO; LEN_LO transfer latches N={hi,lo}.
REQ-023 After LEN_LO: N=0 -> CHK; N>MAX_WORDS -> ERROR; otherwise -> DATA_HI.
REQ-024 DATA_HI transfer latches the high byte -> DATA_LO; DATA_LO transfer -> DATA_HI, or -> CHK if this was word N.
REQ-025 Cycle after each DATA_LO transfer: imem_wr_en=1 for exactly one cycle, imem_wr_data={hi,lo}, imem_wr_addr=BASE_ADDR+4*k (k = 0-based word index); count increments in that same cycle.
REQ-026 Address arithmetic is 16-bit modulo; wrap past 16'hFFFC is not flagged.
REQ-027 Checksum is the 8-bit XOR of all data bytes only (count bytes excluded); N=0 gives expected checksum 8'h00.
REQ-028 CHK transfer: byte equals checksum -> DONE, else -> ERROR.
REQ-029 DONE: done=1, cpu_reset=0, err=0, held until reset or start.
REQ-030 ERROR: err=1, done=0, cpu_reset=1, held until reset or start; written words are not rolled back.
REQ-031 All outputs are registered; done/err/cpu_reset change the cycle after the deciding transfer.
REQ-032 In_valid gaps SHALL stall the FSM in place with no state or output change.
REQ-033 imem_wr_en is 0 in every cycle other than those defined in REQ-025.

Reset
REQ-034 reset=1 SHALL force IDLE in the next cycle, overriding start and any in-flight load.
REQ-035 Reset values: in_ready=0, imem_wr_en=0, imem_wr_addr=16'h0000, imem_wr_data=16'h0000, cpu_reset=1, done=0, err=0, count=0.
REQ-036 A pending write strobe is cancelled by reset; no partial-word write occurs.

Verification
REQ-037 start; bytes 00 02 12 34 AB CD, checksum 12^34^AB^CD=40 -> writes (0x0000,0x1234),(0x0004,0xABCD); count=2; done=1, cpu_reset=0 one cycle after checksum transfer.
REQ-038 Same stream with checksum 41 -> err=1, done=0, cpu_reset=1; count=2.
REQ-039 MAX_WORDS=4, count bytes 00 05 -> ERROR after LEN_LO; in_ready=0; no imem_wr_en pulses.
REQ-040 Count 00 00, checksum 00 -> DONE with count=0 and no writes; checksum 01 -> ERROR.
REQ-041 in_valid toggled every other cycle during REQ-037 stream -> identical writes/results; no state change in idle-valid cycles.
REQ-042 reset asserted after the first data byte -> IDLE, cpu_reset=1, count=0, no write; subsequent start plus REQ-037 stream passes.

Source files
------------

// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a length-prefixed word image with an XOR
// checksum, writes it into instruction memory and releases the CPU on success.
module prog_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        imem_wr_en,
   output logic [15:0] imem_wr_addr,
   output logic [15:0] imem_wr_data,
   output logic        cpu_reset,
   output logic        done,
   output logic        err,
   output logic [15:0] count
);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERROR
   } state_t;

   localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

   state_t      state, state_next;
   logic        xfer;
   logic [7:0]  hi_byte;
   logic [7:0]  csum;
   logic [15:0] len;
   logic [15:0] rx_len;
   logic        last_word;

   assign xfer      = in_valid && in_ready;
   assign rx_len    = {hi_byte, in_data};
   assign last_word = (count + 16'd1) == len;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, ERROR: if (start) state_next = LEN_HI;
         LEN_HI:  if (xfer) state_next = LEN_LO;
         LEN_LO: begin
            if (xfer) begin
               if (rx_len == 16'h0000)            state_next = CHK;
               else if ({1'b0, rx_len} > MAX_LEN) state_next = ERROR;
               else                               state_next = DATA_HI;
            end
         end
         DATA_HI: if (xfer) state_next = DATA_LO;
         DATA_LO: if (xfer) state_next = last_word ? CHK : DATA_HI;
         CHK:     if (xfer) state_next = (in_data == csum) ? DONE : ERROR;
         default: state_next = IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they appear the cycle after the deciding transfer.
   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready     <= 1'b0;
         imem_wr_en   <= 1'b0;
         imem_wr_addr <= '0;
         imem_wr_data <= '0;
         cpu_reset    <= 1'b1;
         done         <= 1'b0;
         err          <= 1'b0;
         count        <= '0;
         hi_byte      <= '0;
         len          <= '0;
         csum         <= '0;
      end else begin
         imem_wr_en <= 1'b0;
         in_ready   <= state_next inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK};
         done       <= state_next == DONE;
         err        <= state_next == ERROR;
         cpu_reset  <= state_next != DONE;
         if (state_next == LEN_HI && state != LEN_HI) begin
            count <= '0;
            csum  <= '0;
         end
         if (xfer) begin
            case (state)
               LEN_HI:  hi_byte <= in_data;
               LEN_LO:  len     <= rx_len;
               DATA_HI: begin
                  hi_byte <= in_data;
                  csum    <= csum ^ in_data;
               end
               DATA_LO: begin
                  csum         <= csum ^ in_data;
                  imem_wr_en   <= 1'b1;
                  imem_wr_data <= {hi_byte, in_data};
                  imem_wr_addr <= BASE_ADDR + {count[13:0], 2'b00};
                  count        <= count + 16'd1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised and directed bench for prog_loader; two instances (default and
// small/high-base parameters) share one stimulus and are checked against a stream model.
module tb_prog_loader;

   typedef logic [7:0] u8;

   logic        clk = 1'b0;
   logic        reset, start, in_valid;
   logic [7:0]  in_data;
   logic        in_ready_o[2], wr_en_o[2], cpu_reset_o[2], done_o[2], err_o[2];
   logic [15:0] wr_addr_o[2], wr_data_o[2], count_o[2];

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic [31:0] got_w[2][$];
   logic [31:0] exp_w[2][$];
   logic        exp_done[2], exp_err[2];
   logic [15:0] exp_cnt[2];
   logic        prev_wr[2];

   localparam int unsigned MAXW[2] = '{1024, 4};
   localparam logic [15:0] BASE[2] = '{16'h0000, 16'hFFF8};

   always #5 clk = ~clk;

   prog_loader dut_a (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_o[0]), .imem_wr_en(wr_en_o[0]), .imem_wr_addr(wr_addr_o[0]),
      .imem_wr_data(wr_data_o[0]), .cpu_reset(cpu_reset_o[0]), .done(done_o[0]),
      .err(err_o[0]), .count(count_o[0])
   );

   prog_loader #(.BASE_ADDR(16'hFFF8), .MAX_WORDS(4)) dut_b (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready_o[1]), .imem_wr_en(wr_en_o[1]), .imem_wr_addr(wr_addr_o[1]),
      .imem_wr_data(wr_data_o[1]), .cpu_reset(cpu_reset_o[1]), .done(done_o[1]),
      .err(err_o[1]), .count(count_o[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Write monitor; a strobe can never be high in two consecutive cycles.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (wr_en_o[i]) begin
            got_w[i].push_back({wr_addr_o[i], wr_data_o[i]});
            chk($sformatf("single_pulse%0d", i), {31'd0, prev_wr[i]}, 32'd0);
         end
         prev_wr[i] = wr_en_o[i];
      end
   end

   // Reference: interpret the whole stream at once.
   task automatic model(input int idx, input u8 q[$]);
      int unsigned n;
      u8 x;
      n = {q[0], q[1]};
      exp_w[idx].delete();
      if (n > MAXW[idx]) begin
         exp_done[idx] = 1'b0; exp_err[idx] = 1'b1; exp_cnt[idx] = 16'd0;
      end else begin
         x = 8'h00;
         for (int k = 0; k < int'(n); k++) begin
            x ^= q[2 + 2*k] ^ q[3 + 2*k];
            exp_w[idx].push_back({16'(BASE[idx] + 16'(4*k)), q[2 + 2*k], q[3 + 2*k]});
         end
         exp_done[idx] = (q[2 + 2*n] == x);
         exp_err[idx]  = !exp_done[idx];
         exp_cnt[idx]  = 16'(n);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk({tag, "_in_ready"},  {31'd0, in_ready_o[i]},  32'd0);
         chk({tag, "_wr_en"},     {31'd0, wr_en_o[i]},     32'd0);
         chk({tag, "_cpu_reset"}, {31'd0, cpu_reset_o[i]}, 32'd1);
         chk({tag, "_done"},      {31'd0, done_o[i]},      32'd0);
         chk({tag, "_err"},       {31'd0, err_o[i]},       32'd0);
         chk({tag, "_count"},     {16'd0, count_o[i]},     32'd0);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("entry_in_ready",  {31'd0, in_ready_o[i]},  32'd1);
         chk("entry_count",     {16'd0, count_o[i]},     32'd0);
         chk("entry_done_err",  {30'd0, done_o[i], err_o[i]}, 32'd0);
         chk("entry_cpu_reset", {31'd0, cpu_reset_o[i]}, 32'd1);
      end
   endtask

   // Entered and left at a falling edge; one byte transfers on dut_a's handshake.
   task automatic send_byte(input u8 b, input bit gap);
      logic [19:0] snap;
      int unsigned waited;
      if (gap) begin
         in_valid = 1'b0;
         snap = {in_ready_o[0], done_o[0], err_o[0], cpu_reset_o[0], count_o[0]};
         @(negedge clk);
         chk("stall_hold", {12'd0, in_ready_o[0], done_o[0], err_o[0], cpu_reset_o[0], count_o[0]},
             {12'd0, snap});
         chk("stall_wr_en", {31'd0, wr_en_o[0]}, 32'd0);
      end
      in_valid = 1'b1;
      in_data  = b;
      waited   = 0;
      while (!in_ready_o[0] && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) chk("handshake_timeout", 32'd1, 32'd0);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_load(input string tag, input u8 q[$], input bit gaps);
      for (int i = 0; i < 2; i++) begin
         got_w[i].delete();
         model(i, q);
      end
      pulse_start();
      foreach (q[j]) send_byte(q[j], gaps && (j % 2 == 1));
      // Sampled one cycle after the checksum transfer.
      for (int i = 0; i < 2; i++) begin
         chk({tag, "_done"},      {31'd0, done_o[i]},       {31'd0, exp_done[i]});
         chk({tag, "_err"},       {31'd0, err_o[i]},        {31'd0, exp_err[i]});
         chk({tag, "_cpu_reset"}, {31'd0, cpu_reset_o[i]},  {31'd0, !exp_done[i]});
         chk({tag, "_count"},     {16'd0, count_o[i]},      {16'd0, exp_cnt[i]});
         chk({tag, "_in_ready"},  {31'd0, in_ready_o[i]},   32'd0);
         chk({tag, "_nwrites"},   got_w[i].size(),          exp_w[i].size());
         foreach (exp_w[i][k])
            if (k < got_w[i].size()) chk({tag, "_write"}, got_w[i][k], exp_w[i][k]);
      end
      @(negedge clk);
      chk({tag, "_hold_done"}, {31'd0, done_o[0]}, {31'd0, exp_done[0]});
   endtask

   initial begin
      u8 q[$];
      u8 x;
      int unsigned n;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      prev_wr[0] = 1'b0; prev_wr[1] = 1'b0;
      repeat (2) @(negedge clk);
      // reset beats a simultaneous start
      start = 1'b1;
      @(negedge clk);
      check_reset_vals("reset");
      chk("reset_addr", {16'd0, wr_addr_o[0]}, 32'd0);
      chk("reset_data", {16'd0, wr_data_o[0]}, 32'd0);
      start = 1'b0; reset = 1'b0;
      @(negedge clk);

      q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      run_load("basic", q, 1'b0);
      q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
      run_load("badchk", q, 1'b0);
      q = '{8'h00, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
            8'h09, 8'h0A, 8'h0B};
      run_load("oversize", q, 1'b0);
      q = '{8'h00, 8'h00, 8'h00};
      run_load("empty_ok", q, 1'b0);
      q = '{8'h00, 8'h00, 8'h01};
      run_load("empty_bad", q, 1'b0);
      q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      run_load("gapped", q, 1'b1);
      q = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
      run_load("wrap", q, 1'b0);

      // reset after the first data byte
      for (int i = 0; i < 2; i++) got_w[i].delete();
      pulse_start();
      send_byte(8'h00, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h12, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_vals("midreset");
      @(negedge clk);
      chk("midreset_nowrite", got_w[0].size() + got_w[1].size(), 32'd0);

      // reset coincident with the low-byte transfer cancels the strobe
      pulse_start();
      send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0); send_byte(8'hAB, 1'b0);
      in_valid = 1'b1; in_data = 8'hCD; reset = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; reset = 1'b0;
      check_reset_vals("wrreset");
      @(negedge clk);
      chk("wrreset_nowrite", got_w[0].size() + got_w[1].size(), 32'd0);

      q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
      run_load("after_reset", q, 1'b0);

      for (int r = 0; r < 12; r++) begin
         n = $urandom_range(0, 6);
         q = '{8'h00, 8'(n)};
         x = 8'h00;
         for (int k = 0; k < int'(2*n); k++) begin
            q.push_back(8'($urandom));
            x ^= q[q.size() - 1];
         end
         if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
         q.push_back(x);
         run_load($sformatf("rand%0d", r), q, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
